uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmitter. Accepts one parallel word per handshake, latches it, and serializes it LSB-first.
- Computes the parity bit and drives the 2-bit select of the TX output mux through start, data, parity and stop phases.
- Sits between the register/FIFO read side and the TX output mux. Runs on the TX baud clock: one CLK cycle equals one bit period.

Parameters:
- DATA_WIDTH, 8, width of the parallel word and number of data bits per frame (legal range 5-9).

Ports:
- CLK  input  1  TX bit clock; all state changes on rising edge
- RST  input  1  reset, synchronous, active-low
- P_DATA  input  DATA_WIDTH  parallel word to transmit
- DATA_VALID  input  1  request pulse/level; P_DATA, PAR_EN and PAR_TYP are valid with it
- PAR_EN  input  1  1 = insert parity bit after data
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- SER_DATA  output  1  current data bit for the mux (latched word shifted LSB-first)
- PAR_BIT  output  1  parity bit of the latched word
- MUX_SEL  output  2  mux select: 00 start, 01 data, 10 parity, 11 stop/idle
- BUSY  output  1  high while a frame is on the line

Behaviour:
- Reset: RST=0 at a rising edge puts state in IDLE and forces MUX_SEL=11, BUSY=0, SER_DATA=0, PAR_BIT=0, bit counter=0, shift register=0. All outputs are registered.
- States are IDLE, START, DATA, PARITY, STOP, with one cycle per bit except DATA, which lasts DATA_WIDTH cycles.
- IDLE:
  - MUX_SEL=11 (line high), BUSY=0.
  - DATA_VALID=1 sampled at edge N latches P_DATA, PAR_EN and PAR_TYP, then goes to START.
  - At cycle N+1: MUX_SEL=00 and BUSY=1.
- START: one cycle, then DATA. Bit counter is cleared, and SER_DATA presents P_DATA[0] from the first DATA cycle.
- DATA:
  - MUX_SEL=01.
  - SER_DATA shifts right one bit per cycle.
  - The counter counts 0..DATA_WIDTH-1. At count DATA_WIDTH-1 the next state is PARITY if the latched PAR_EN=1, else STOP.
- PARITY: MUX_SEL=10 for one cycle, then STOP.
- PAR_BIT is computed from the latched word and registered at latch time:
  - even: PAR_BIT = XOR-reduce of the data;
  - odd: PAR_BIT = inverse of that XOR-reduce.
  - PAR_BIT is stable for the whole frame.
- STOP:
  - MUX_SEL=11 for one cycle, BUSY=1.
  - If DATA_VALID=1 at the end of STOP, the new word is latched and the next state is START (back-to-back, no idle gap, BUSY stays 1).
  - Otherwise the next state is IDLE with BUSY=0.
- Frame length is 1 + DATA_WIDTH + PAR_EN + 1 cycles.
- DATA_VALID in START, DATA or PARITY is ignored and not queued. Upstream must hold or re-present the request until BUSY=0, or present it in the STOP cycle.
- Configuration changes to PAR_EN/PAR_TYP mid-frame have no effect on the frame in flight.
- Reset mid-frame: at the next edge the block is in IDLE with MUX_SEL=11. The partial frame is abandoned and never resumed.
- MUX_SEL never takes an unlisted value. An illegal state encoding recovers to IDLE.

Decomposition:
- Shared package uart_tx_pkg holds:
  - MUX_SEL encodings (SEL_START=2'b00, SEL_DATA=2'b01, SEL_PARITY=2'b10, SEL_STOP=2'b11);
  - state encodings;
  - PAR_EVEN/PAR_ODD constants.
- One natural sub-module: uart_tx_serializer, which holds the shift register, the bit counter and the done flag. The FSM and parity logic stay in uart_tx_ctrl.

Test Plan:
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle DATA_VALID:
  - MUX_SEL sequence is 00, 01×8, 10, 11 over 11 cycles;
  - SER_DATA=1,0,1,0,0,1,0,1; PAR_BIT=0;
  - BUSY high for exactly 11 cycles, then MUX_SEL=11 and BUSY=0.
- P_DATA=0x01, PAR_EN=1: PAR_TYP=0 gives PAR_BIT=1; PAR_TYP=1 gives PAR_BIT=0.
- P_DATA=0x3C, PAR_EN=0 -> 10-cycle frame with no 10 select; SER_DATA=0,0,1,1,1,1,0,0.
- Two words 0x55 then 0xAA, second DATA_VALID asserted in the STOP cycle of the first -> next cycle MUX_SEL=00, BUSY never drops, second frame correct.
- DATA_VALID with P_DATA=0xFF asserted during the DATA phase of a 0x00 frame -> frame bits unchanged, no second frame, BUSY=0 after stop.
- RST=0 during the 4th DATA cycle -> next cycle MUX_SEL=11, BUSY=0, SER_DATA=0; a fresh DATA_VALID afterwards yields a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_pkg                                                   |
// | Purpose  : Shared encodings for the UART transmit frame sequencer:       |
// |            TX mux select codes, FSM state encoding, parity type codes    |
// |            and the parity helper.                                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package uart_tx_pkg;

  // TX output mux select codes
  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_STOP   = 2'b11;  // also the idle (line high) code

  // PAR_TYP codes
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Frame sequencer states; three bits leave three unused codes that
  // the FSM folds back into ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // data_xor is the XOR-reduce of the word. Even parity transmits it
  // directly; odd parity transmits its inverse.
  function automatic logic calc_parity(input logic data_xor, input logic par_typ);
    return data_xor ^ (par_typ == PAR_ODD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_ctrl_if                                               |
// | Purpose  : Bundle between the register/FIFO read side, the frame         |
// |            sequencer and the TX output mux.                              |
// |   P_DATA     : parallel word to transmit                                 |
// |   DATA_VALID : request; P_DATA/PAR_EN/PAR_TYP valid with it              |
// |   PAR_EN     : 1 = append a parity bit                                   |
// |   PAR_TYP    : 0 = even, 1 = odd parity                                  |
// |   SER_DATA   : current data bit for the mux                              |
// |   PAR_BIT    : parity bit of the latched word                            |
// |   MUX_SEL    : 00 start, 01 data, 10 parity, 11 stop/idle                |
// |   BUSY       : high while a frame is on the line                         |
// |   master = request side, slave = uart_tx_ctrl                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  SER_DATA;
  logic                  PAR_BIT;
  logic [1:0]            MUX_SEL;
  logic                  BUSY;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  SER_DATA, PAR_BIT, MUX_SEL, BUSY
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output SER_DATA, PAR_BIT, MUX_SEL, BUSY
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_serializer                                            |
// | Purpose  : Shift register, bit counter and done flag of the TX frame.    |
// |   CLK, RST   : bit clock, synchronous active-low reset                   |
// |   i_load     : capture i_data, clear counter                              |
// |   i_data     : word to serialize                                          |
// |   i_start    : present bit 0 on o_ser_data next cycle, clear counter      |
// |   i_shift    : present next bit, advance counter                          |
// |   o_ser_data : registered current data bit                                |
// |   o_done     : counter is on the last data bit                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  wire logic                  CLK,
  input  wire logic                  RST,
  input  wire logic                  i_load,
  input  wire logic [DATA_WIDTH-1:0] i_data,
  input  wire logic                  i_start,
  input  wire logic                  i_shift,
  output logic                       o_ser_data,
  output logic                       o_done
);

  localparam int                 c_cnt_w = $clog2(DATA_WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_ser;

  // o_ser_data is registered, so the bit shown in a DATA cycle is the one
  // popped off the shift register at the edge that entered it.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_ser   <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_ser   <= r_shift[0];
      r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_ser   <= r_shift[0];
      r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
      r_cnt   <= r_cnt + c_cnt_w'(1);
    end
  end

  assign o_ser_data = r_ser;
  assign o_done     = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_ctrl                                                  |
// | Purpose  : UART TX frame sequencer. Latches one word per request and     |
// |            steps the TX mux through start, data (LSB first), optional    |
// |            parity and stop bits, one bit per CLK cycle.                  |
// |   CLK : TX bit clock                                                     |
// |   RST : synchronous, active-low reset                                    |
// |   bus : uart_tx_ctrl_if.slave (P_DATA, DATA_VALID, PAR_EN, PAR_TYP in;   |
// |         SER_DATA, PAR_BIT, MUX_SEL, BUSY out, all registered)            |
// |   DATA_WIDTH (5..9) must match the interface instance.                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  wire logic     CLK,
  input  wire logic     RST,
  uart_tx_ctrl_if.slave bus
);

  tx_state_t  r_state;
  logic [1:0] r_mux_sel;
  logic       r_busy;
  logic       r_par_bit;
  logic       r_par_en;

  logic       w_accept;
  logic       w_start;
  logic       w_shift;
  logic       w_done;
  logic       w_ser_data;

  // Requests are only taken when idle or in the stop bit; anything else
  // is dropped, not queued.
  assign w_accept = bus.DATA_VALID && (r_state == ST_IDLE || r_state == ST_STOP);
  assign w_start  = (r_state == ST_START);
  assign w_shift  = (r_state == ST_DATA) && !w_done;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .CLK        (CLK),
    .RST        (RST),
    .i_load     (w_accept),
    .i_data     (bus.P_DATA),
    .i_start    (w_start),
    .i_shift    (w_shift),
    .o_ser_data (w_ser_data),
    .o_done     (w_done)
  );

  // Outputs are registered together with the state so MUX_SEL/BUSY always
  // describe the state being entered.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_mux_sel <= SEL_STOP;
      r_busy    <= 1'b0;
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
    end else begin
      case (r_state)
        // IDLE and STOP share the accept path; that is what allows a
        // back-to-back frame with no idle bit in between.
        ST_IDLE, ST_STOP: begin
          if (bus.DATA_VALID) begin
            r_state   <= ST_START;
            r_mux_sel <= SEL_START;
            r_busy    <= 1'b1;
            r_par_en  <= bus.PAR_EN;
            r_par_bit <= calc_parity(^bus.P_DATA, bus.PAR_TYP);
          end else begin
            r_state   <= ST_IDLE;
            r_mux_sel <= SEL_STOP;
            r_busy    <= 1'b0;
          end
        end
        ST_START: begin
          r_state   <= ST_DATA;
          r_mux_sel <= SEL_DATA;
        end
        ST_DATA: begin
          if (w_done) begin
            if (r_par_en) begin
              r_state   <= ST_PARITY;
              r_mux_sel <= SEL_PARITY;
            end else begin
              r_state   <= ST_STOP;
              r_mux_sel <= SEL_STOP;
            end
          end
        end
        ST_PARITY: begin
          r_state   <= ST_STOP;
          r_mux_sel <= SEL_STOP;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mux_sel <= SEL_STOP;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MUX_SEL  = r_mux_sel;
  assign bus.BUSY     = r_busy;
  assign bus.PAR_BIT  = r_par_bit;
  assign bus.SER_DATA = w_ser_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_tx_ctrl                                               |
// | Purpose  : Self-checking bench for uart_tx_ctrl. Expected per-cycle      |
// |            outputs come from a frame model that lists the bit periods    |
// |            of each frame.                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_WIDTH(W)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Observation vector: {MUX_SEL[1:0], BUSY, SER_DATA, PAR_BIT}
  typedef struct {
    logic [4:0] val;
    logic [4:0] mask;
    bit         mid;   // START/DATA/PARITY cycle: a request here is ignored
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [4:0] obs();
    return {bus.MUX_SEL, bus.BUSY, bus.SER_DATA, bus.PAR_BIT};
  endfunction

  // One frame: start, W data bits LSB first, optional parity, stop.
  // The parity bit makes the total count of ones even (typ=0) or odd (typ=1).
  function automatic void push_frame(input logic [W-1:0] word, input bit en, input bit typ);
    int   ones;
    logic p;
    ones = $countones(word);
    p    = ((ones + int'(typ)) % 2) == 1;
    exp_q.push_back('{val: {2'b00, 1'b1, 1'b0, p}, mask: 5'b11101, mid: 1'b1});
    for (int k = 0; k < W; k++)
      exp_q.push_back('{val: {2'b01, 1'b1, word[k], p}, mask: 5'b11111, mid: 1'b1});
    if (en)
      exp_q.push_back('{val: {2'b10, 1'b1, 1'b0, p}, mask: 5'b11101, mid: 1'b1});
    exp_q.push_back('{val: {2'b11, 1'b1, 1'b0, p}, mask: 5'b11101, mid: 1'b0});
  endfunction

  function automatic void push_idle(input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back('{val: 5'b11000, mask: 5'b11100, mid: 1'b0});
  endfunction

  task automatic drive_req(input logic [W-1:0] word, input bit en, input bit typ);
    bus.DATA_VALID = 1'b1;
    bus.P_DATA     = word;
    bus.PAR_EN     = en;
    bus.PAR_TYP    = typ;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.DATA_VALID = 1'b1;
    bus.P_DATA     = 8'hFF;
    bus.PAR_EN     = 1'b1;
    bus.PAR_TYP    = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== 5'b11000) begin
      failures++;
      $display("FAIL reset_state got=%b exp=11000", obs());
    end
    bus.DATA_VALID = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs() !== 5'b11000) begin
        failures++;
        $display("FAIL idle_after_reset cyc=%0d got=%b exp=11000", i, obs());
      end
    end
  endtask

  task automatic test_frames();
    logic [W-1:0] words [4] = '{8'hA5, 8'h01, 8'h01, 8'h3C};
    bit           ens   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit           typs  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int t = 0; t < 4; t++) begin
      exp_q.delete();
      push_frame(words[t], ens[t], typs[t]);
      push_idle(2);
      @(negedge clk);
      drive_req(words[t], ens[t], typs[t]);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        checks++;
        if ((obs() & exp_q[i].mask) !== (exp_q[i].val & exp_q[i].mask)) begin
          failures++;
          $display("FAIL frame_%0h cyc=%0d got=%b exp=%b mask=%b",
                   words[t], i, obs(), exp_q[i].val, exp_q[i].mask);
        end
        bus.DATA_VALID = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    int stop_idx;
    exp_q.delete();
    push_frame(8'h55, 1'b1, 1'b0);
    stop_idx = exp_q.size() - 1;
    push_frame(8'hAA, 1'b0, 1'b1);
    push_idle(2);
    @(negedge clk);
    drive_req(8'h55, 1'b1, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if ((obs() & exp_q[i].mask) !== (exp_q[i].val & exp_q[i].mask)) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b mask=%b",
                 i, obs(), exp_q[i].val, exp_q[i].mask);
      end
      if (i == stop_idx) drive_req(8'hAA, 1'b0, 1'b1);
      else bus.DATA_VALID = 1'b0;
    end
  endtask

  task automatic test_ignored_request();
    exp_q.delete();
    push_frame(8'h00, 1'b1, 1'b0);
    push_idle(3);
    @(negedge clk);
    drive_req(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if ((obs() & exp_q[i].mask) !== (exp_q[i].val & exp_q[i].mask)) begin
        failures++;
        $display("FAIL ignored_req cyc=%0d got=%b exp=%b mask=%b",
                 i, obs(), exp_q[i].val, exp_q[i].mask);
      end
      // Request plus config change during the data bits must not leak in
      if (i >= 2 && i <= 4) drive_req(8'hFF, 1'b0, 1'b1);
      else bus.DATA_VALID = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] w;
    bit           en;
    bit           typ;
    exp_q.delete();
    push_frame(8'hC3, 1'b1, 1'b1);
    @(negedge clk);
    drive_req(8'hC3, 1'b1, 1'b1);
    // Entries 1..4 are the first four data bits; reset lands on the 4th.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ((obs() & exp_q[i].mask) !== (exp_q[i].val & exp_q[i].mask)) begin
        failures++;
        $display("FAIL pre_reset cyc=%0d got=%b exp=%b mask=%b",
                 i, obs(), exp_q[i].val, exp_q[i].mask);
      end
      bus.DATA_VALID = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== 5'b11000) begin
      failures++;
      $display("FAIL mid_frame_reset got=%b exp=11000", obs());
    end
    rst_n = 1'b1;
    w   = W'($urandom);
    en  = 1'($urandom);
    typ = 1'($urandom);
    exp_q.delete();
    push_idle(1);
    push_frame(w, en, typ);
    push_idle(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if ((obs() & exp_q[i].mask) !== (exp_q[i].val & exp_q[i].mask)) begin
        failures++;
        $display("FAIL post_reset_frame cyc=%0d got=%b exp=%b mask=%b",
                 i, obs(), exp_q[i].val, exp_q[i].mask);
      end
      if (i == 0) drive_req(w, en, typ);
      else bus.DATA_VALID = 1'b0;
    end
  endtask

  task automatic test_random();
    int           req_at [$];
    logic [W-1:0] req_w  [$];
    bit           req_en [$];
    bit           req_ty [$];
    exp_q.delete();
    push_idle(1);
    for (int r = 0; r < 16; r++) begin
      logic [W-1:0] w;
      bit           en;
      bit           typ;
      if (r > 0 && $urandom_range(0, 2) != 0) push_idle($urandom_range(1, 3));
      req_at.push_back(exp_q.size() - 1);
      w   = W'($urandom);
      en  = 1'($urandom);
      typ = 1'($urandom);
      req_w.push_back(w);
      req_en.push_back(en);
      req_ty.push_back(typ);
      push_frame(w, en, typ);
    end
    push_idle(2);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if ((obs() & exp_q[i].mask) !== (exp_q[i].val & exp_q[i].mask)) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b mask=%b",
                 i, obs(), exp_q[i].val, exp_q[i].mask);
      end
      if (req_at.size() > 0 && req_at[0] == i) begin
        drive_req(req_w.pop_front(), req_en.pop_front(), req_ty.pop_front());
        void'(req_at.pop_front());
      end else begin
        bus.DATA_VALID = exp_q[i].mid && ($urandom_range(0, 3) == 0);
        bus.P_DATA     = W'($urandom);
        bus.PAR_EN     = 1'($urandom);
        bus.PAR_TYP    = 1'($urandom);
      end
    end
    bus.DATA_VALID = 1'b0;
  endtask

  initial begin
    bus.DATA_VALID = 1'b0;
    bus.P_DATA     = '0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    test_reset();
    test_frames();
    test_back_to_back();
    test_ignored_request();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
